// File: rtl/pix_mux_rr_sched.sv
// Round-robin scheduler sharing one pixel path among four sources, bursts of up to BURST beats.
// Latency: one arbitration cycle per grant, then one registered beat per cycle.
// Backpressure: beats stall while dout is held and dout_ready is low; the grant is kept unless req drops.
module pix_mux_rr_sched #(
    parameter int WIDTH = 9,
    parameter int BURST = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       req,
    input  logic [WIDTH-1:0] din_a,
    input  logic [WIDTH-1:0] din_b,
    input  logic [WIDTH-1:0] din_c,
    input  logic [WIDTH-1:0] din_d,
    output logic [3:0]       ack,
    output logic [1:0]       sel,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             busy
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] XFER = 1'b1;

    logic [0:0]       state;
    logic [1:0]       last_grant;
    logic [3:0]       beat_cnt;
    logic [1:0]       grant_idx;
    logic             grant_any;
    logic [1:0]       cand;
    logic [WIDTH-1:0] din_sel;
    logic             xfer;
    logic             release_grant;

    // Scan upward from the source after the last grant, wrapping 3->0.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = last_grant;
        cand      = last_grant;
        for (int i = 1; i <= 4; i++) begin
            cand = last_grant + 2'(i);
            if (!grant_any && req[cand]) begin
                grant_any = 1'b1;
                grant_idx = cand;
            end
        end
    end

    always_comb begin
        case (sel)
            2'd0:    din_sel = din_a;
            2'd1:    din_sel = din_b;
            2'd2:    din_sel = din_c;
            default: din_sel = din_d;
        endcase
    end

    assign busy          = (state == XFER);
    assign xfer          = busy && req[sel] && (!dout_valid || dout_ready);
    assign ack           = xfer ? (4'b0001 << sel) : 4'b0000;
    assign release_grant = (xfer && (beat_cnt == 4'(BURST - 1))) || (busy && !req[sel]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            sel        <= 2'd0;
            last_grant <= 2'd3;
            beat_cnt   <= 4'd0;
            dout       <= '0;
            dout_valid <= 1'b0;
        end else begin
            if (xfer) begin
                dout       <= din_sel;
                dout_valid <= 1'b1;
                beat_cnt   <= beat_cnt + 4'd1;
            end else if (dout_ready) begin
                dout_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (grant_any) begin
                        sel      <= grant_idx;
                        beat_cnt <= 4'd0;
                        state    <= XFER;
                    end
                end
                default: begin
                    if (release_grant) begin
                        last_grant <= sel;
                        state      <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pix_mux_rr_sched.sv
// Scoreboard bench: per-source pixel queues feed the DUT; a round-robin burst model predicts output order.
module tb_pix_mux_rr_sched;
    localparam int WIDTH = 9;
    localparam int BURST = 3;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [3:0]       req = 4'b0;
    logic [WIDTH-1:0] din_v [4];
    logic [3:0]       ack;
    logic [1:0]       sel;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             dout_ready = 1'b1;
    logic             busy;

    pix_mux_rr_sched #(.WIDTH(WIDTH), .BURST(BURST)) dut (
        .clk(clk), .rst_n(rst_n), .req(req),
        .din_a(din_v[0]), .din_b(din_v[1]), .din_c(din_v[2]), .din_d(din_v[3]),
        .ack(ack), .sel(sel), .dout(dout), .dout_valid(dout_valid),
        .dout_ready(dout_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    int               checks = 0;
    int               errors = 0;
    logic [WIDTH-1:0] src_q [4][$];
    logic [WIDTH-1:0] exp_q [$];
    int               model_last = 3;
    logic [3:0]       ack_s = 4'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, act, exp_v, $time);
        end
    endtask

    // Whole-stream prediction: each grant takes min(BURST, pending) pixels from the next requester.
    task automatic model_load();
        logic [WIDTH-1:0] m [4][$];
        int               n;
        bit               found;
        for (int s = 0; s < 4; s++) m[s] = src_q[s];
        while (m[0].size() + m[1].size() + m[2].size() + m[3].size() > 0) begin
            found = 1'b0;
            for (int k = 1; k <= 4; k++) begin
                int s;
                s = (model_last + k) % 4;
                if (!found && m[s].size() > 0) begin
                    found = 1'b1;
                    n = (m[s].size() < BURST) ? m[s].size() : BURST;
                    for (int j = 0; j < n; j++) exp_q.push_back(m[s].pop_front());
                    model_last = s;
                end
            end
        end
    endtask

    task automatic load_random(input int maxlen);
        int n;
        for (int s = 0; s < 4; s++) begin
            n = $urandom_range(0, maxlen);
            for (int j = 0; j < n; j++) src_q[s].push_back(WIDTH'($urandom));
        end
        model_load();
    endtask

    function automatic bit all_empty();
        return (src_q[0].size() + src_q[1].size() + src_q[2].size() + src_q[3].size()) == 0;
    endfunction

    task automatic run_round(input bit rand_rdy, input int budget, input int stop_at, output int cycles);
        cycles = 0;
        while (1) begin
            @(negedge clk);
            for (int s = 0; s < 4; s++) if (ack_s[s] && src_q[s].size() > 0) void'(src_q[s].pop_front());
            ack_s = 4'b0;
            if (all_empty()) break;
            if (cycles >= budget) begin
                chk("round_timeout", cycles, 0);
                break;
            end
            for (int s = 0; s < 4; s++) begin
                req[s]   = (src_q[s].size() != 0);
                din_v[s] = (src_q[s].size() != 0) ? src_q[s][0] : WIDTH'($urandom);
            end
            dout_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
            #1;
            ack_s = ack;
            cycles++;
            if (stop_at != 0 && cycles == stop_at) return;
        end
        req = 4'b0;
        dout_ready = 1'b1;
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
        chk("drain_left", exp_q.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    // Monitor: scoreboard pops on each accepted beat, plus ack/sel/stall protocol checks.
    logic             pv_busy = 1'b0;
    logic             pv_stall = 1'b0;
    logic [1:0]       pv_sel = 2'd0;
    logic [WIDTH-1:0] pv_dout = '0;
    always @(negedge clk) begin
        #2;
        if (!rst_n) begin
            pv_busy  = 1'b0;
            pv_stall = 1'b0;
        end else begin
            if (ack != 4'b0) begin
                chk("ack_onehot_sel", ack, 4'b0001 << sel);
                chk("ack_busy", busy, 1);
            end
            if (pv_busy) chk("sel_stable", sel, pv_sel);
            if (pv_stall) begin
                chk("stall_dout", dout, pv_dout);
                chk("stall_valid", dout_valid, 1);
            end
            if (dout_valid && dout_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat got %0h expected none at %0t", dout, $time);
                end else begin
                    chk("dout", dout, exp_q.pop_front());
                end
            end
            pv_busy  = busy;
            pv_sel   = sel;
            pv_stall = dout_valid && !dout_ready;
            pv_dout  = dout;
        end
    end

    int cyc;
    initial begin
        for (int s = 0; s < 4; s++) din_v[s] = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_sel", sel, 0);
        chk("rst_dout", dout, 0);
        chk("rst_valid", dout_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ack", ack, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // All four requesting at full rate: each grant is 1 idle + BURST beats.
        for (int s = 0; s < 4; s++)
            for (int j = 0; j < BURST; j++)
                src_q[s].push_back((s == 0) ? 9'h1A5 : WIDTH'($urandom));
        model_load();
        run_round(1'b0, 200, 0, cyc);
        chk("full_rate_cycles", cyc, 4 * (BURST + 1));

        for (int r = 0; r < 20; r++) begin
            load_random(8);
            run_round(1'b1, 2000, 0, cyc);
        end

        // Asynchronous reset in the middle of a source-3 burst.
        for (int j = 0; j < 6; j++) src_q[3].push_back(WIDTH'($urandom));
        model_load();
        run_round(1'b0, 100, 3, cyc);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_valid", dout_valid, 0);
        chk("mid_rst_dout", dout, 0);
        chk("mid_rst_sel", sel, 0);
        chk("mid_rst_ack", ack, 0);
        for (int s = 0; s < 4; s++) src_q[s].delete();
        exp_q.delete();
        ack_s = 4'b0;
        req = 4'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_last = 3;
        for (int j = 0; j < 2; j++) begin
            src_q[0].push_back(WIDTH'($urandom));
            src_q[3].push_back(WIDTH'($urandom));
        end
        model_load();
        run_round(1'b1, 200, 0, cyc);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
